multi_nco_gen: RTL

MULTI_NCO_GEN -- requirements
Module: multi_nco_gen

---
 rtl/multi_nco_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/multi_nco_gen.sv
// multi_nco_gen: multi-channel NCO with per-channel step/mode/offset, wrap-synchronised reconfiguration
// and a two-stage waveform lookup producing in-phase and quadrature samples.
module multi_nco_gen #(
    parameter int N_CH    = 2,
    parameter int PHASE_W = 16,
    parameter int CH_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [PHASE_W-1:0]   cfg_step,
    input  logic [PHASE_W-1:0]   cfg_offset,
    input  logic [1:0]           cfg_mode,
    input  logic                 cfg_now,
    output logic [8*N_CH-1:0]    wave_out,
    output logic [8*N_CH-1:0]    quad_out,
    output logic                 out_valid
);
    localparam logic [7:0] QTAB [65] = '{
        8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,  8'd25,  8'd28,
        8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,  8'd49,  8'd51,  8'd54,  8'd57,
        8'd60,  8'd63,  8'd65,  8'd68,  8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,
        8'd85,  8'd88,  8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
        8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116, 8'd117, 8'd118,
        8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124, 8'd125, 8'd125, 8'd126, 8'd126,
        8'd126, 8'd127, 8'd127, 8'd127, 8'd127
    };

    // Quarter-wave table mirrored across k=64 and negated for the second half-cycle.
    function automatic logic [7:0] shape(input logic [7:0] k, input logic [1:0] m);
        logic [7:0] a;
        a = QTAB[k[6] ? 7'd64 - {1'b0, k[5:0]} : {1'b0, k[5:0]}];
        return m == 2'd0 ? (k[7] ? 8'd128 - a : 8'd128 + a) :
               m == 2'd1 ? (k[7] ? 8'd1 : 8'd255) :
               m == 2'd2 ? (k[7] ? ~{k[6:0], 1'b0} : {k[6:0], 1'b1}) : k;
    endfunction

    logic v1;

    assign cfg_ready = reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= enable;
            out_valid <= enable & v1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [PHASE_W-1:0] phase, step, offset, p_step, p_offset;
        logic [1:0]         mode, p_mode, m1;
        logic               pend, hit, wrap;
        logic [7:0]         k1, w, q;
        logic [PHASE_W:0]   sum;

        assign sum  = {1'b0, phase} + {1'b0, step};
        // Carry for positive steps, absence of carry (borrow) for negative ones.
        assign wrap = enable & ~sync & (sum[PHASE_W] ^ step[PHASE_W-1]);
        assign hit  = cfg_valid & cfg_ready & (cfg_ch == CH_W'(c));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                phase    <= '0;
                step     <= '0;
                offset   <= '0;
                mode     <= '0;
                p_step   <= '0;
                p_offset <= '0;
                p_mode   <= '0;
                pend     <= 1'b0;
                k1       <= '0;
                m1       <= '0;
                w        <= '0;
                q        <= '0;
            end else begin
                if (sync)
                    phase <= offset;
                else if (enable)
                    phase <= sum[PHASE_W-1:0];
                if (hit && cfg_now) begin
                    step   <= cfg_step;
                    mode   <= cfg_mode;
                    offset <= cfg_offset;
                    pend   <= 1'b0;
                end else begin
                    if (wrap && pend) begin
                        step   <= p_step;
                        mode   <= p_mode;
                        offset <= p_offset;
                    end
                    if (hit) begin
                        p_step   <= cfg_step;
                        p_mode   <= cfg_mode;
                        p_offset <= cfg_offset;
                        pend     <= 1'b1;
                    end else if (wrap)
                        pend <= 1'b0;
                end
                if (enable) begin
                    k1 <= phase[PHASE_W-1 -: 8];
                    m1 <= mode;
                    w  <= shape(k1, m1);
                    q  <= shape(k1 + 8'd64, m1);
                end
            end
        end

        assign wave_out[8*c +: 8] = w;
        assign quad_out[8*c +: 8] = q;
    end
endmodule
